// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   size_e  : access width encoding as seen on req_size (2'b11 is illegal).
//   state_e : LSU control states.
//   addr_limit(): highest legal start address for a 4-byte RAM access.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    READ,
    WRITE,
    RESP
  } state_e;

  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // The RAM always touches addr..addr+3. The result is 33 bits wide so that
  // a full 32-bit address can be compared against it without wrapping.
  function automatic logic [32:0] addr_limit(input int unsigned mem_size);
    return 33'(mem_size) - 33'd4;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: core-side request/response channel of the load/store unit.
//   req_*: request (valid/ready), rsp_*: response (valid/ready).
//   modport master = core (issues requests), modport slave = lsu.
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: load data extraction/extension and sub-word store merge.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: size/uns select width and extension, mem_rdata is the RAM word,
//        wdata the store data; load_data / store_data are the results.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic        uns,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  always_comb begin
    load_data  = mem_rdata;
    store_data = wdata;
    case (size)
      BYTE: begin
        load_data  = uns ? {24'd0, mem_rdata[7:0]}
                         : {{24{mem_rdata[7]}}, mem_rdata[7:0]};
        // No byte enables on the RAM: keep the three upper bytes as read.
        store_data = {mem_rdata[31:8], wdata[7:0]};
      end
      HALF: begin
        load_data  = uns ? {16'd0, mem_rdata[15:0]}
                         : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
        store_data = {mem_rdata[31:16], wdata[15:0]};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit driving a byte-addressed 32-bit RAM with no byte enables.
// Latency from request handshake edge to rsp_valid: load 3, word store 3,
//   sub-word store 4 (read-modify-write), rejected request 2 edges.
// Backpressure: one request outstanding; req_ready only in IDLE, the response
//   is held stable until rsp_ready.
// Ports: clk, rst_n (async, active-low); bus = core request/response channel;
//   mem_addr/mem_we/mem_wdata/mem_rdata = RAM port (combinational read,
//   write on rising edge while mem_we).
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_if.slave        bus,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // All outputs are registers so nothing on req_* reaches mem_* combinationally.
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [31:0] mem_addr_q;
  logic        mem_we_q;
  logic [31:0] mem_wdata_q;

  logic        bad_req;
  logic        word_store;
  logic [31:0] load_data;
  logic [31:0] store_data;

  assign bad_req    = (size_q == SIZE_ILLEGAL) ||
                      ({1'b0, addr_q} > addr_limit(MEM_SIZE));
  assign word_store = we_q && (size_q == WORD);

  lsu_align u_align (
    .size       (size_e'(size_q)),
    .uns        (uns_q),
    .mem_rdata  (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            size_q      <= bus.req_size;
            uns_q       <= bus.req_unsigned;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            state       <= CHECK;
          end
        end
        CHECK: begin
          if (bad_req) begin
            // Rejected requests never touch the RAM.
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 32'd0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else if (word_store) begin
            mem_addr_q  <= addr_q;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= wdata_q;
            state       <= WRITE;
          end else begin
            mem_addr_q  <= addr_q;
            state       <= READ;
          end
        end
        READ: begin
          if (we_q) begin
            // Sub-word store: write back the read word with the new low bytes.
            mem_we_q    <= 1'b1;
            mem_wdata_q <= store_data;
            state       <= WRITE;
          end else begin
            mem_addr_q  <= 32'd0;
            rsp_rdata_q <= load_data;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        WRITE: begin
          mem_addr_q  <= 32'd0;
          mem_we_q    <= 1'b0;
          mem_wdata_q <= 32'd0;
          rsp_rdata_q <= 32'd0;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          mem_addr_q  <= 32'd0;
          mem_we_q    <= 1'b0;
          mem_wdata_q <= 32'd0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized + directed bench for lsu with a byte-array reference
// model and a response scoreboard; the RAM is a behavioural byte array.
module tb_lsu;

  localparam int MEM_SIZE = 4096;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_if bus ();

  lsu #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: combinational little-endian read, write on rising edge.
  logic [7:0]  ram [MEM_SIZE];
  logic [11:0] ra;
  assign ra = mem_addr[11:0];
  assign mem_rdata = {ram[ra + 12'd3], ram[ra + 12'd2], ram[ra + 12'd1], ram[ra]};

  always @(posedge clk) begin
    if (mem_we) begin
      ram[ra]         <= mem_wdata[7:0];
      ram[ra + 12'd1] <= mem_wdata[15:8];
      ram[ra + 12'd2] <= mem_wdata[23:16];
      ram[ra + 12'd3] <= mem_wdata[31:24];
    end
  end

  int edge_cnt = 0;
  int we_cnt   = 0;
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain byte array, updated in request order.
  logic [7:0] ref_mem [MEM_SIZE];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] wword;
    logic [31:0] waddr;
    int          lat;
    int          writes;
    int          hs;
    int          hold;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    longint unsigned val;
    int n;
    int a;
    e.rdata = 32'd0; e.err = 1'b0; e.wword = 32'd0; e.waddr = 32'd0;
    e.lat = 0; e.writes = 0; e.hs = 0; e.hold = 0;
    if (size == 2'b11 || longint'(addr) > longint'(MEM_SIZE - 4)) begin
      e.err = 1'b1;
      e.lat = 2;
      return e;
    end
    a = int'(addr);
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    if (!we) begin
      val = 0;
      for (int i = 0; i < n; i++) val += longint'(ref_mem[a + i]) << (8 * i);
      if (!uns && n < 4 && val >= (64'd1 << (8 * n - 1)))
        val = val + 64'h1_0000_0000 - (64'd1 << (8 * n));
      e.rdata = val[31:0];
      e.lat = 3;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8 * i +: 8];
      e.wword  = {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
      e.waddr  = addr;
      e.writes = 1;
      e.lat    = (n == 4) ? 3 : 4;
    end
    return e;
  endfunction

  // Driver: called at a negedge; holds req_valid until the unit is ready.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    exp_t e;
    int t;
    bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    t = 0;
    while (!bus.req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    e = model(we, size, uns, addr, wdata);
    e.hs   = edge_cnt + 1;
    e.hold = hold;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we = 1'($urandom); bus.req_size = 2'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.rsp_valid || !bus.req_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   {31'd0, bus.rsp_err}, 32'd0);
    chk({tag, "_mem_addr"},  mem_addr, 32'd0);
    chk({tag, "_mem_we"},    {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  // Monitor: pops the scoreboard on each new response and owns rsp_ready.
  initial begin : monitor
    exp_t e;
    int lw;
    lw = 0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {31'd0, bus.rsp_valid}, 32'd0);
          bus.rsp_ready = 1'b1;
          @(negedge clk);
          bus.rsp_ready = 1'b0;
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
          chk("latency", 32'(edge_cnt - e.hs), 32'(e.lat - 1));
          chk("mem_we_pulses", 32'(we_cnt - lw), 32'(e.writes));
          lw = we_cnt;
          for (int i = 0; i < e.hold; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("hold_rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("hold_rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
            chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
          end
          bus.rsp_ready = 1'b1;
          @(negedge clk);
          bus.rsp_ready = 1'b0;
          chk("accept_req_ready", {31'd0, bus.req_ready}, 32'd1);
          chk("accept_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        end
      end
    end
  end

  // Every RAM write must carry the address and merged word of the current store.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (sb.size() == 0) begin
        chk("write_without_request", {31'd0, mem_we}, 32'd0);
      end else begin
        chk("write_addr", mem_addr, sb[0].waddr);
        chk("write_data", mem_wdata, sb[0].wword);
      end
    end
  end

  initial begin : stim
    logic [31:0] a;
    logic [1:0]  sz;
    logic [7:0]  orig;
    for (int i = 0; i < MEM_SIZE; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[16'h10] = 8'h80; ram[16'h11] = 8'h7F; ram[16'h12] = 8'h01; ram[16'h13] = 8'h02;
    ram[16'h21] = 8'h11; ram[16'h22] = 8'h22; ram[16'h23] = 8'h33; ram[16'h24] = 8'h44;
    for (int i = 16'h10; i <= 16'h24; i++) ref_mem[i] = ram[i];

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("after_reset");

    // Extraction and extension.
    issue(1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h10, 32'd0, 1);
    issue(1'b0, 2'b01, 1'b0, 32'h10, 32'd0, 2);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0);
    // Sub-word read-modify-write.
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFAB, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h21, 32'd0, 0);
    // Unaligned word store, neighbours untouched.
    issue(1'b1, 2'b10, 1'b0, 32'h33, 32'hDEAD_BEEF, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h33, 32'd0, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h32, 32'd0, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h37, 32'd0, 0);
    // Range and size errors.
    issue(1'b0, 2'b10, 1'b0, 32'hFFC, 32'd0, 0);
    issue(1'b0, 2'b10, 1'b0, 32'hFFD, 32'd0, 0);
    issue(1'b1, 2'b00, 1'b0, 32'hFFD, 32'h1234_5678, 0);
    issue(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd0, 0);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 0);
    issue(1'b1, 2'b11, 1'b0, 32'h10, 32'h5555_5555, 0);
    // Long backpressure with the next request already waiting.
    issue(1'b0, 2'b01, 1'b1, 32'h11, 32'd0, 5);
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF, 5);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0);
    drain();

    // Asynchronous reset during the READ cycle of a byte store.
    orig = ram[16'h40];
    bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h40; bus.req_wdata = 32'h0000_005A; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("read_cycle_addr", mem_addr, 32'h40);
    chk("read_cycle_we", {31'd0, mem_we}, 32'd0);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ram_after_abort", {24'd0, ram[16'h40]}, {24'd0, ref_mem[16'h40]});
    chk("ram_after_abort_orig", {24'd0, ram[16'h40]}, {24'd0, orig});
    issue(1'b0, 2'b00, 1'b1, 32'h40, 32'd0, 0);
    issue(1'b1, 2'b01, 1'b0, 32'h40, 32'h0000_C3A5, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 0);

    // Randomized traffic over a small window plus the range boundary.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(4088, 4095));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 63));
      endcase
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      issue(1'($urandom), sz, 1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit that acts as the initiator on the byte-addressed 32-bit RAM port (combinational read of the four bytes at `addr..addr+3`, synchronous write of all four bytes when `we` is high). It accepts byte, halfword and word load/store requests from the core over a valid/ready handshake. Sub-word stores are performed as read-modify-write, because the RAM has no byte enables. It extracts and sign- or zero-extends load data, and returns one response per request.

## Interface
- `MEM_SIZE`, 4096: RAM size in bytes; must equal the RAM instance's `MEM_SIZE`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; the low `size` bytes are used.
- `rsp_valid` out 1: response present; held until accepted.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: request rejected (out-of-range address or illegal size).
- `mem_addr` out 32: to RAM `addr`.
- `mem_we` out 1: to RAM `we`.
- `mem_wdata` out 32: to RAM `data_in`.
- `mem_rdata` in 32: from RAM `data_out`.

## Operation
- States: IDLE, CHECK, READ, WRITE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, register we/size/unsigned/addr/wdata, then go to CHECK.
- CHECK:
  - Error if `req_size`==11 or `addr > MEM_SIZE-4`. The compare is done in 33 bits so that an address near 2^32 cannot wrap.
  - On error: set err, set rdata=0, go to RESP. The RAM is never accessed.
  - Load or sub-word store: go to READ.
  - Word store: go to WRITE.
- READ:
  - Drive `mem_addr`=addr and capture `mem_rdata`.
  - Load: extract the low byte or half and extend per `unsigned`; a word passes through unchanged. Then go to RESP.
  - Sub-word store: merge the captured word with `wdata`. Byte replaces [7:0], half replaces [15:0], upper bytes are preserved. Then go to WRITE.
- WRITE: `mem_addr`=addr, `mem_we`=1, `mem_wdata`=merged word or full `wdata`, then go to RESP.
- RESP: `rsp_valid`=1. When `rsp_ready`=1, go to IDLE.
- The address need not be aligned; the RAM handles any byte address within range.
- Outside READ/WRITE: `mem_addr`=0, `mem_we`=0, `mem_wdata`=0.
- Reset (asynchronous, any state): go to IDLE and clear all registered fields.
  - An in-flight write is abandoned. The RAM is written only on a rising edge while `mem_we`=1, so no partial write occurs.
  - Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_addr`=0, `mem_we`=0, `mem_wdata`=0.

## Timing
- Handshake occurs on edge 0.
- `rsp_valid` rises after:
  - load: 3 edges;
  - word store: 3 edges;
  - sub-word store: 4 edges;
  - error: 2 edges.
- `rsp_valid`, `rsp_rdata` and `rsp_err` are stable while `rsp_ready`=0.
- Response accepted on edge N means `req_ready`=1 from edge N, so the next request can be accepted on edge N+1 at the earliest. There is no pipelining; at most one request is outstanding.
- `mem_*` outputs are registered or decoded from registered state only. There is no combinational path from `req_*` to `mem_*`.
- Read data is sampled at the end of the READ cycle; the RAM read path is combinational.

## Structure
- Package `lsu_pkg`:
  - `size_e` enum: BYTE, HALF, WORD.
  - `state_e` enum: IDLE, CHECK, READ, WRITE, RESP.
  - Function or constant for the range limit.
- Sub-module `lsu_align` (purely combinational):
  - Inputs: size, unsigned, `mem_rdata`, `wdata`.
  - Outputs: extended load data, merged store word.
- The FSM and registers stay in `lsu`.

## Test plan
1. RAM bytes 0x10..0x13 = 80 7F 01 02.
   - Byte load @0x10, signed: `rsp_rdata`=0xFFFFFF80.
   - Same load, unsigned: 0x00000080.
   - Half load @0x10, signed: 0x00007F80.
2. Byte store 0xAB @0x21 over word 0x44332211 at 0x21:
   - one READ cycle, then `mem_we` pulses exactly once with 0x443322AB;
   - a following word load @0x21 returns 0x443322AB;
   - latency is 4 edges.
3. Word store 0xDEADBEEF @0x33 (unaligned): a word load @0x33 returns 0xDEADBEEF, and the bytes at 0x32 and 0x37 are unchanged.
4. With `MEM_SIZE`=4096:
   - load @0xFFC succeeds;
   - load @0xFFD gives `rsp_err`=1, `rsp_rdata`=0, and `mem_we` is never asserted;
   - `req_addr`=0xFFFFFFFF gives `rsp_err`=1;
   - `req_size`=11 gives `rsp_err`=1.
5. Hold `rsp_ready`=0 for 5 cycles:
   - `rsp_*` stay stable and `req_ready` stays 0;
   - a new `req_valid` is ignored until 1 cycle after acceptance.
6. Assert `rst_n`=0 asynchronously during the READ cycle of a byte store:
   - all outputs go immediately to their reset values;
   - the RAM is unchanged;
   - a new request after reset completes normally.
